pulse_gen: RTL
==============

# pulse_gen

Multi-channel, runtime-programmable pulse generator: the parametrised successor to the fixed-timing power-on pulse block. Each channel takes a start strobe and then emits a train of pulses. Delay, high length, low gap and repeat count are latched per channel at start. Used for reset sequencing, strobe generation and periodic ticks from a single system clock.

## Interface
- `CH`, default 4: number of independent channels.
- `W`, default 16: width of every timing/count field, in cycles.

- `clk` in 1: system clock; all logic on rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `start` in CH: per-channel start strobe; sampled each edge.
- `abort` in CH: per-channel abort; sampled each edge.
- `dly` in CH*W: channel c at [c*W +: W]; cycles from start to first rising edge.
- `len` in CH*W: pulse high length in cycles; 0 = no pulse.
- `gap` in CH*W: low cycles between pulses; 0 is treated as 1.
- `rep` in CH*W: number of pulses; 0 = continuous until abort.
- `pulse` out CH: registered pulse output.
- `busy` out CH: channel is active (any state other than IDLE).
- `done` out CH: one-cycle strobe when a train completes normally.

## Operation
- Reset: all channels go to IDLE. `pulse`, `busy`, `done` = 0; counters = 0.
- Per-channel FSM:
  - IDLE -> DLY on `start`. Latch `dly`/`len`/`gap`/`rep`; load cnt = dly; load remaining = rep.
  - DLY: decrement cnt. At 0 -> HIGH (cnt = len), or straight to finish if len == 0.
  - HIGH: pulse = 1; decrement cnt. Leaving HIGH, decrement remaining (unless rep == 0).
    - remaining hits 0: finish.
    - otherwise -> GAP with cnt = max(gap,1).
  - GAP: pulse = 0; at 0 -> HIGH (cnt = len).
  - Finish: -> IDLE, `done` = 1 for one cycle.
- `start` while busy is ignored. Inputs changing after start have no effect on the current train.
- `abort` has priority over everything, including a simultaneous `start` in IDLE:
  - next edge: IDLE, pulse = 0, busy = 0, no `done`.
- Channels are fully independent; no shared state.
- Counters are W-bit down-counters. Maximum field value 2^W-1 must work without wrap.

## Timing
- Start sampled at edge T:
  - `busy` = 1 from edge T.
  - First `pulse` rise at edge T+1+dly.
  - High for exactly len cycles.
- Pulse k (k ≥ 1) rises at T+1+dly+(k-1)*(len+max(gap,1)).
- `done` and the final `pulse` fall occur on the same edge; `busy` falls on that edge too.
- len == 0: no pulse. `done` at edge T+1+dly.
- New `start` accepted on the edge after `done` (back-to-back trains spaced by ≥1 idle cycle).
- rep == 0: `done` never asserts; the train runs until `abort`.
- Reset mid-train: outputs go to 0 asynchronously, with no `done`.

## Structure
- Package `pulse_gen_pkg`: state enum {IDLE, DLY, HIGH, GAP} and a `GAP_MIN = 1` constant.
- Sub-module `pulse_gen_ch`: one channel FSM plus counters, parameter `W`. The top level is a generate loop over `CH` plus bus slicing.

## Test plan
- dly=3, len=2, rep=1, start at T=10: pulse high at edges 14–15; done at 16; busy at 10–15.
- dly=0, len=1, gap=0, rep=3: pulses rise at T+1, T+3, T+5, each 1 cycle; done with the third fall.
- len=0, dly=5, rep=2: pulse stays 0; done at T+6.
- rep=0, len=2, gap=3: periodic with period 5. Abort during HIGH -> pulse 0 and busy 0 next edge; no done. Abort+start together in IDLE -> stays IDLE.
- All four channels started on different cycles with different configs: each matches the formula independently. start while busy is ignored. dly=65535 (W=16) completes correctly.
- Assert rst mid-GAP and mid-HIGH: immediate zero outputs. Restart after release behaves as from power-up.

Source files
------------

// File: rtl/pulse_gen_pkg.sv
// Shared types and constants for the multi-channel pulse generator.
package pulse_gen_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DLY  = 2'd1,
        HIGH = 2'd2,
        GAP  = 2'd3
    } state_t;

    localparam int unsigned GAP_MIN = 1;

endpackage

// File: rtl/pulse_gen_if.sv
// Control/status bundle for pulse_gen; channel c timing fields live at [c*W +: W].
interface pulse_gen_if #(
    parameter int unsigned CH = 4,
    parameter int unsigned W  = 16
);
    logic [CH-1:0]   start;
    logic [CH-1:0]   abort;
    logic [CH*W-1:0] dly;
    logic [CH*W-1:0] len;
    logic [CH*W-1:0] gap;
    logic [CH*W-1:0] rep;
    logic [CH-1:0]   pulse;
    logic [CH-1:0]   busy;
    logic [CH-1:0]   done;

    modport master (
        output start, abort, dly, len, gap, rep,
        input  pulse, busy, done
    );

    modport slave (
        input  start, abort, dly, len, gap, rep,
        output pulse, busy, done
    );
endinterface

// File: rtl/pulse_gen_ch.sv
// One pulse-train channel: delay, then rep pulses of len high / gap low cycles.
module pulse_gen_ch
    import pulse_gen_pkg::*;
#(
    parameter int unsigned W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         abort,
    input  logic [W-1:0] dly,
    input  logic [W-1:0] len,
    input  logic [W-1:0] gap,
    input  logic [W-1:0] rep,
    output logic         pulse,
    output logic         busy,
    output logic         done
);

    state_t       state;
    logic [W-1:0] cnt;
    logic [W-1:0] remaining;
    logic [W-1:0] len_q;
    logic [W-1:0] gap_q;
    logic         cont_q;

    // cnt holds cycles left minus one in HIGH/GAP, so full-scale fields never wrap
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            remaining <= '0;
            len_q     <= '0;
            gap_q     <= '0;
            cont_q    <= 1'b0;
            pulse     <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            if (abort) begin
                state <= IDLE;
                cnt   <= '0;
                pulse <= 1'b0;
                busy  <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (start) begin
                            state     <= DLY;
                            busy      <= 1'b1;
                            cnt       <= dly;
                            remaining <= rep;
                            len_q     <= len;
                            gap_q     <= (gap == '0) ? W'(GAP_MIN) : gap;
                            cont_q    <= (rep == '0);
                        end
                    end
                    DLY: begin
                        if (cnt != '0) begin
                            cnt <= cnt - W'(1);
                        end else if (len_q == '0) begin
                            state <= IDLE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end else begin
                            state <= HIGH;
                            pulse <= 1'b1;
                            cnt   <= len_q - W'(1);
                        end
                    end
                    HIGH: begin
                        if (cnt != '0) begin
                            cnt <= cnt - W'(1);
                        end else begin
                            pulse <= 1'b0;
                            if (!cont_q && remaining == W'(1)) begin
                                state <= IDLE;
                                busy  <= 1'b0;
                                done  <= 1'b1;
                            end else begin
                                if (!cont_q) remaining <= remaining - W'(1);
                                state <= GAP;
                                cnt   <= gap_q - W'(1);
                            end
                        end
                    end
                    GAP: begin
                        if (cnt != '0) begin
                            cnt <= cnt - W'(1);
                        end else begin
                            state <= HIGH;
                            pulse <= 1'b1;
                            cnt   <= len_q - W'(1);
                        end
                    end
                    default: begin
                        state <= IDLE;
                        pulse <= 1'b0;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: rtl/pulse_gen.sv
// Multi-channel pulse generator: CH independent channels sliced from flat buses.
module pulse_gen
    import pulse_gen_pkg::*;
#(
    parameter int unsigned CH = 4,
    parameter int unsigned W  = 16
) (
    input  logic        clk,
    input  logic        rst,
    pulse_gen_if.slave  bus
);

    for (genvar c = 0; c < CH; c++) begin : g_ch
        pulse_gen_ch #(
            .W (W)
        ) u_ch (
            .clk   (clk),
            .rst   (rst),
            .start (bus.start[c]),
            .abort (bus.abort[c]),
            .dly   (bus.dly[c*W +: W]),
            .len   (bus.len[c*W +: W]),
            .gap   (bus.gap[c*W +: W]),
            .rep   (bus.rep[c*W +: W]),
            .pulse (bus.pulse[c]),
            .busy  (bus.busy[c]),
            .done  (bus.done[c])
        );
    end

endmodule
